// File: rtl/sd_req_sched.sv
// sd_req_sched: shares one SD engine between two requesters, with init/retry sequencing,
// round-robin grants and per-request done/error reporting.
module sd_req_sched #(
  parameter int AW           = 32,
  parameter int INIT_TIMEOUT = 2_000_000,
  parameter int INIT_RETRY   = 3,
  parameter int OP_TIMEOUT   = 1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          op0,
  input  logic          op1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  input  logic          reinit,
  output logic          sd_init,
  input  logic          init_ok,
  output logic          eng_start,
  output logic          eng_op,
  output logic [AW-1:0] eng_addr,
  input  logic          eng_done,
  input  logic          eng_err,
  output logic          eng_abort,
  output logic          ready,
  output logic          init_fail
);
  localparam int TMAX = INIT_TIMEOUT > OP_TIMEOUT ? INIT_TIMEOUT : OP_TIMEOUT;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int RW = $clog2(INIT_RETRY + 1);
  localparam logic [TW-1:0] INIT_LAST = TW'(INIT_TIMEOUT - 1);
  localparam logic [TW-1:0] OP_LAST = TW'(OP_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_N = RW'(INIT_RETRY);
  typedef enum logic [2:0] {INIT, INIT_WAIT, IDLE, WAIT_OP, FAIL} state_t;
  state_t state_q;
  logic [TW-1:0] cnt_q;
  logic [RW-1:0] att_q, att_d;
  logic last_q, port_q, win1_d, sd_init_q, start_q, abort_q, op_q;
  logic [1:0] gnt_q, done_q, err_q;
  logic [AW-1:0] addr_q;
  // last_q = 1 means port 1 was granted last, so a tie goes to port 0
  assign win1_d = req1 & (~req0 | ~last_q);
  assign att_d = att_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q <= '0;
      att_q <= '0;
      last_q <= 1'b1;
      port_q <= 1'b0;
      gnt_q <= '0;
      done_q <= '0;
      err_q <= '0;
      sd_init_q <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      op_q <= 1'b0;
      addr_q <= '0;
    end else begin
      gnt_q <= '0;
      done_q <= '0;
      err_q <= '0;
      sd_init_q <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        INIT: begin
          sd_init_q <= 1'b1;
          cnt_q <= '0;
          state_q <= INIT_WAIT;
        end
        INIT_WAIT:
          if (init_ok) begin
            att_q <= '0;
            state_q <= IDLE;
          end else if (cnt_q == INIT_LAST) begin
            att_q <= att_d;
            state_q <= att_d < RETRY_N ? INIT : FAIL;
          end else cnt_q <= cnt_q + 1'b1;
        IDLE:
          if (reinit) begin
            att_q <= '0;
            state_q <= INIT;
          end else if (req0 | req1) begin
            gnt_q <= win1_d ? 2'b10 : 2'b01;
            start_q <= 1'b1;
            op_q <= win1_d ? op1 : op0;
            addr_q <= win1_d ? addr1 : addr0;
            last_q <= win1_d;
            port_q <= win1_d;
            cnt_q <= '0;
            state_q <= WAIT_OP;
          end
        WAIT_OP:
          // a completion on the final timeout cycle still counts as a normal completion
          if (eng_done || cnt_q == OP_LAST) begin
            done_q <= port_q ? 2'b10 : 2'b01;
            err_q <= (~eng_done | eng_err) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
            abort_q <= ~eng_done;
            state_q <= IDLE;
          end else cnt_q <= cnt_q + 1'b1;
        FAIL:
          if (reinit) begin
            att_q <= '0;
            state_q <= INIT;
          end
        default: state_q <= INIT;
      endcase
    end
  end
  assign {gnt1, gnt0} = gnt_q;
  assign {done1, done0} = done_q;
  assign {err1, err0} = err_q;
  assign sd_init = sd_init_q;
  assign eng_start = start_q;
  assign eng_op = op_q;
  assign eng_addr = addr_q;
  assign eng_abort = abort_q;
  assign ready = (state_q == IDLE) | (state_q == WAIT_OP);
  assign init_fail = state_q == FAIL;
endmodule

// File: tb/tb_sd_req_sched.sv
// tb_sd_req_sched: directed test of sd_req_sched with short init/op timeouts.
module tb_sd_req_sched;
  logic clk = 0, rst = 1;
  logic req0 = 0, req1 = 0, op0 = 0, op1 = 0, reinit = 0, init_ok = 0, eng_done = 0, eng_err = 0;
  logic [31:0] addr0 = 0, addr1 = 0, eng_addr;
  logic gnt0, gnt1, done0, done1, err0, err1, sd_init, eng_start, eng_op, eng_abort, ready, init_fail;
  int n_cmp = 0, n_bad = 0;

  sd_req_sched #(.AW(32), .INIT_TIMEOUT(8), .INIT_RETRY(3), .OP_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .reinit(reinit), .sd_init(sd_init), .init_ok(init_ok),
    .eng_start(eng_start), .eng_op(eng_op), .eng_addr(eng_addr), .eng_done(eng_done),
    .eng_err(eng_err), .eng_abort(eng_abort), .ready(ready), .init_fail(init_fail)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int pulses, fail_at;
    int pk[3];
    logic [1:0] exp_g[3];
    logic [31:0] exp_a[3];
    pulses = 0;
    fail_at = -1;
    pk = '{0, 0, 0};
    exp_g = '{2'b01, 2'b10, 2'b01};
    exp_a = '{32'hA0, 32'hB1, 32'hA0};
    // reset state
    repeat (3) tick;
    check("rst_sd_init", sd_init, 0);
    check("rst_ready", ready, 0);
    check("rst_eng_addr", eng_addr, 0);
    check("rst_init_fail", init_fail, 0);
    check("rst_gnt", {gnt1, gnt0}, 0);
    rst = 0;
    // init failure: three attempts of 8+1 cycles, then FAIL
    for (int k = 1; k <= 30; k++) begin
      tick;
      if (sd_init) begin
        if (pulses < 3) pk[pulses] = k;
        pulses++;
      end
      if (init_fail && fail_at < 0) fail_at = k;
    end
    check("init_pulses", pulses, 3);
    check("init_pulse0", pk[0], 1);
    check("init_pulse1", pk[1], 10);
    check("init_pulse2", pk[2], 19);
    check("init_fail_at", fail_at, 27);
    check("fail_ready", ready, 0);
    // reinit from FAIL, then clean init with init_ok 5 cycles after sd_init
    reinit = 1;
    tick;
    reinit = 0;
    check("reinit_leave_fail", init_fail, 0);
    tick;
    check("reinit_sd_init", sd_init, 1);
    repeat (4) tick;
    check("pre_ok_ready", ready, 0);
    check("pre_ok_sd_init", sd_init, 0);
    init_ok = 1;
    tick;
    check("ok_ready", ready, 1);
    // contention: both held for three grants
    req0 = 1; op0 = 0; addr0 = 32'hA0;
    req1 = 1; op1 = 1; addr1 = 32'hB1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("cont_gnt%0d", i), {gnt1, gnt0}, exp_g[i]);
      check($sformatf("cont_addr%0d", i), eng_addr, exp_a[i]);
      check($sformatf("cont_start%0d", i), eng_start, 1);
      tick;
      eng_done = 1;
      tick;
      eng_done = 0;
      check($sformatf("cont_done%0d", i), {done1, done0}, exp_g[i]);
    end
    req0 = 0; req1 = 0;
    tick;
    // single request
    req0 = 1; op0 = 1; addr0 = 32'h100;
    tick;
    req0 = 0;
    check("single_gnt", {gnt1, gnt0}, 2'b01);
    check("single_start", eng_start, 1);
    check("single_addr", eng_addr, 32'h100);
    check("single_op", eng_op, 1);
    tick;
    check("single_gnt_pulse", gnt0, 0);
    eng_done = 1; eng_err = 0;
    tick;
    eng_done = 0;
    check("single_done", {done1, done0, err1, err0}, 4'b0100);
    tick;
    check("single_done_pulse", done0, 0);
    check("single_addr_hold", eng_addr, 32'h100);
    // op timeout on port 1
    req1 = 1; op1 = 0; addr1 = 32'h77;
    tick;
    req1 = 0;
    check("to_gnt", {gnt1, gnt0}, 2'b10);
    check("to_addr", eng_addr, 32'h77);
    repeat (15) tick;
    check("to_early", {done1, eng_abort}, 0);
    tick;
    check("to_fire", {done1, err1, eng_abort}, 3'b111);
    tick;
    // eng_done on the final counter cycle beats the timeout
    req1 = 1;
    tick;
    req1 = 0;
    repeat (15) tick;
    eng_done = 1;
    tick;
    eng_done = 0;
    check("to_race", {done1, err1, eng_abort}, 3'b100);
    tick;
    // reinit in WAIT_OP is ignored; error completion reported
    req0 = 1;
    tick;
    req0 = 0;
    check("wo_gnt", gnt0, 1);
    reinit = 1;
    tick;
    reinit = 0;
    tick;
    check("wo_no_init", sd_init, 0);
    check("wo_ready", ready, 1);
    eng_done = 1; eng_err = 1;
    tick;
    eng_done = 0; eng_err = 0;
    check("wo_done_err", {done0, err0, eng_abort}, 3'b110);
    // reinit in IDLE beats a pending request
    req0 = 1; reinit = 1;
    tick;
    reinit = 0;
    check("idle_reinit_gnt", gnt0, 0);
    check("idle_reinit_ready", ready, 0);
    tick;
    check("idle_reinit_sd_init", sd_init, 1);
    check("idle_reinit_gnt2", gnt0, 0);
    tick;
    check("reinit_ready_back", ready, 1);
    tick;
    req0 = 0;
    check("reinit_then_gnt", gnt0, 1);
    // reset mid-operation aborts silently
    tick;
    rst = 1;
    tick;
    check("midrst_outs", {done0, done1, eng_abort, ready}, 0);
    check("midrst_addr", eng_addr, 0);
    rst = 0;
    tick;
    check("midrst_sd_init", sd_init, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
